// File: rtl/delta_tracker_if.sv
// Pixel-stream input and frame-result output bundle for delta_tracker.
// pix_valid has no back-pressure: the tracker takes every pixel that is offered.
// A result is transferred on a rising edge where box_valid=1 and box_ready=1.
// While box_valid=1 and box_ready=0, the result fields hold still until a newer frame overwrites them.
interface delta_tracker_if #(
  parameter int COORD_WIDTH = 10,
  parameter int CNT_WIDTH   = 19
);
  logic                   pix_valid;
  logic                   sof;
  logic [COORD_WIDTH-1:0] delta_frame;
  logic                   box_valid;
  logic                   box_ready;
  logic [COORD_WIDTH-1:0] x_min;
  logic [COORD_WIDTH-1:0] x_max;
  logic [COORD_WIDTH-1:0] y_min;
  logic [COORD_WIDTH-1:0] y_max;
  logic [COORD_WIDTH-1:0] center_x;
  logic [COORD_WIDTH-1:0] center_y;
  logic [CNT_WIDTH-1:0]   pix_count;
  logic                   detected;
  logic                   overrun;

  modport master (
    output pix_valid, sof, delta_frame, box_ready,
    input  box_valid, x_min, x_max, y_min, y_max, center_x, center_y,
           pix_count, detected, overrun
  );

  modport slave (
    input  pix_valid, sof, delta_frame, box_ready,
    output box_valid, x_min, x_max, y_min, y_max, center_x, center_y,
           pix_count, detected, overrun
  );
endinterface

// File: rtl/delta_tracker.sv
// Accumulates the bounding box, the centre and the count of hot pixels over one frame of a delta mask.
// The tracker publishes that result on the same edge that accepts the frame's last pixel.
module delta_tracker #(
  parameter int COORD_WIDTH = 10,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int CNT_WIDTH   = 19,
  parameter int MIN_PIXELS  = 64
) (
  input  logic              clk,
  input  logic              aresetn,
  delta_tracker_if.slave    bus,
  output logic              fsm_state
);
  typedef enum logic {WAIT_SOF = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic [COORD_WIDTH-1:0] X_LAST  = COORD_WIDTH'(H_ACTIVE - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST  = COORD_WIDTH'(V_ACTIVE - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MIN = CNT_WIDTH'(MIN_PIXELS);

  state_t                 state;
  logic [COORD_WIDTH-1:0] col, row;
  logic [COORD_WIDTH-1:0] wx_min, wx_max, wy_min, wy_max;
  logic [CNT_WIDTH-1:0]   wcnt;

  logic                   start, take, hot, last, col_wrap, empty;
  logic [COORD_WIDTH-1:0] px, py;
  logic [COORD_WIDTH-1:0] b_xmin, b_xmax, b_ymin, b_ymax;
  logic [COORD_WIDTH-1:0] n_xmin, n_xmax, n_ymin, n_ymax;
  logic [CNT_WIDTH-1:0]   b_cnt, n_cnt;
  logic [COORD_WIDTH:0]   sum_x, sum_y;

  // A sof pixel always starts a fresh frame at (0,0), whether idle or mid-frame.
  always_comb begin
    start    = bus.pix_valid && bus.sof;
    take     = bus.pix_valid && (state == ACCUM || bus.sof);
    hot      = bus.delta_frame != '0;
    px       = start ? '0 : col;
    py       = start ? '0 : row;
    b_xmin   = start ? '1 : wx_min;
    b_ymin   = start ? '1 : wy_min;
    b_xmax   = start ? '0 : wx_max;
    b_ymax   = start ? '0 : wy_max;
    b_cnt    = start ? '0 : wcnt;
    n_xmin   = (hot && px < b_xmin) ? px : b_xmin;
    n_xmax   = (hot && px > b_xmax) ? px : b_xmax;
    n_ymin   = (hot && py < b_ymin) ? py : b_ymin;
    n_ymax   = (hot && py > b_ymax) ? py : b_ymax;
    n_cnt    = b_cnt + {{(CNT_WIDTH-1){1'b0}}, hot};
    col_wrap = px == X_LAST;
    last     = col_wrap && (py == Y_LAST);
    empty    = n_cnt == '0;
    sum_x    = {1'b0, n_xmin} + {1'b0, n_xmax};
    sum_y    = {1'b0, n_ymin} + {1'b0, n_ymax};
  end

  assign fsm_state = (state == ACCUM);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= WAIT_SOF;
      col           <= '0;
      row           <= '0;
      wx_min        <= '0;
      wx_max        <= '0;
      wy_min        <= '0;
      wy_max        <= '0;
      wcnt          <= '0;
      bus.box_valid <= 1'b0;
      bus.x_min     <= '0;
      bus.x_max     <= '0;
      bus.y_min     <= '0;
      bus.y_max     <= '0;
      bus.center_x  <= '0;
      bus.center_y  <= '0;
      bus.pix_count <= '0;
      bus.detected  <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (take) begin
        if (last) begin
          state  <= WAIT_SOF;
          col    <= '0;
          row    <= '0;
          wx_min <= '0;
          wx_max <= '0;
          wy_min <= '0;
          wy_max <= '0;
          wcnt   <= '0;
        end else begin
          state  <= ACCUM;
          col    <= col_wrap ? '0 : px + 1'b1;
          row    <= col_wrap ? py + 1'b1 : py;
          wx_min <= n_xmin;
          wx_max <= n_xmax;
          wy_min <= n_ymin;
          wy_max <= n_ymax;
          wcnt   <= n_cnt;
        end
      end
      // An empty frame reports zeros rather than the all-ones min seeds.
      if (take && last) begin
        bus.box_valid <= 1'b1;
        bus.x_min     <= empty ? '0 : n_xmin;
        bus.x_max     <= empty ? '0 : n_xmax;
        bus.y_min     <= empty ? '0 : n_ymin;
        bus.y_max     <= empty ? '0 : n_ymax;
        bus.center_x  <= empty ? '0 : COORD_WIDTH'(sum_x >> 1);
        bus.center_y  <= empty ? '0 : COORD_WIDTH'(sum_y >> 1);
        bus.pix_count <= n_cnt;
        bus.detected  <= n_cnt >= CNT_MIN;
        if (bus.box_valid && !bus.box_ready) bus.overrun <= 1'b1;
      end else if (bus.box_ready) begin
        bus.box_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/delta_tracker.md
DELTA_TRACKER -- requirements
Module: delta_tracker

Interface
REQ-001 Parameter COORD_WIDTH, default 10: width of the pixel coordinate and delta_frame buses.
REQ-002 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-003 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-004 Parameter CNT_WIDTH, default 19: hot-pixel counter width; must hold H_ACTIVE*V_ACTIVE.
REQ-005 Parameter MIN_PIXELS, default 64: minimum hot-pixel count for a detection.
REQ-006 clk  input  1  clock; all logic is rising-edge.
REQ-007 aresetn  input  1  reset, asynchronous, active-low.
REQ-008 pix_valid  input  1  delta_frame carries an active pixel this cycle.
REQ-009 sof  input  1  start of frame, qualified by pix_valid; marks pixel (0,0).
REQ-010 delta_frame  input  COORD_WIDTH  saturated delta mask pixel, all-ones or all-zeros.
REQ-011 box_valid  output  1  result registers hold an unaccepted frame result.
REQ-012 box_ready  input  1  consumer accepts the result when box_valid=1.
REQ-013 x_min, x_max, y_min, y_max  output  COORD_WIDTH each  bounding box of hot pixels.
REQ-014 center_x, center_y  output  COORD_WIDTH each  bounding-box midpoint.
REQ-015 pix_count  output  CNT_WIDTH  hot-pixel count for the frame.
REQ-016 detected  output  1  pix_count >= MIN_PIXELS.
REQ-017 overrun  output  1  sticky flag: an unaccepted result was overwritten.

Function
REQ-018 A pixel is hot when delta_frame != 0 and pix_valid=1.
REQ-019 The FSM shall have two states: WAIT_SOF and ACCUM.
REQ-020 In WAIT_SOF, pixels without sof are ignored; pix_valid&sof enters ACCUM and processes that pixel as (0,0).
REQ-021 The col counter increments on each accepted pixel and wraps from H_ACTIVE-1 to 0, at which point row increments.
REQ-022 Working min registers initialise to all-ones and max/count registers to 0 at frame start; each hot pixel updates min/max and increments count.
REQ-023 The last pixel is (H_ACTIVE-1, V_ACTIVE-1); the cycle after it is accepted, the result registers load, box_valid=1, and the FSM returns to WAIT_SOF.
REQ-024 Result latency: exactly 1 clk from the last pixel's pix_valid edge to box_valid high.
REQ-025 center = (min+max)>>1, computed with a COORD_WIDTH+1 intermediate and no overflow.
REQ-026 A frame with zero hot pixels reports all four box coordinates as 0, center as 0, pix_count 0 and detected 0.
REQ-027 box_valid stays high with outputs stable until a cycle with box_ready=1, then drops unless a new result loads in the same cycle.
REQ-028 A new result loading while box_valid=1 and box_ready=0 shall overwrite the outputs and set overrun; overrun is cleared only by reset.
REQ-029 If box_ready=1 in the same cycle a new result loads, the old result counts as accepted, the new one loads, box_valid stays 1, and overrun is unchanged.
REQ-030 sof on any pixel in ACCUM aborts the current frame without reporting and restarts accumulation with that pixel as (0,0).
REQ-031 Cycles with pix_valid=0 hold all counters and working registers.

Reset
REQ-032 When aresetn=0, the FSM enters WAIT_SOF, and col, row, working registers and all outputs go to 0 (box_valid=0, overrun=0), regardless of clk.
REQ-033 Reset mid-frame discards the partial frame, and no result is produced until the next sof.

Verification
REQ-034 A single hot pixel at (100,50) in a 640x480 frame gives x_min=x_max=100, y_min=y_max=50, center=(100,50), pix_count=1, detected=0, with box_valid 1 clk after the last pixel.
REQ-035 A 10x10 hot block at (200..209, 300..309) gives box 200/209/300/309, center (204,304), pix_count=100, detected=1.
REQ-036 An all-zero frame gives all outputs 0 with box_valid=1; then box_ready=1 for one cycle drops box_valid.
REQ-037 Two frames with box_ready held at 0 give box_valid=1 with frame-2 values and overrun=1; a repeat with box_ready=1 on the load cycle gives overrun=0.
REQ-038 sof reasserted at (320,240) mid-frame restarts accumulation: exactly one result appears, reflecting only the pixels after the restart.
REQ-039 aresetn pulsed low at (0,100) gives all outputs 0 immediately, and pixels before the next sof are ignored.
